// File: rtl/fft_out_framer.sv
// Re-packs the inverse-FFT clock-enabled sample stream into a valid/ready stream with
// first/last frame markers, rounding IWIDTH -> OWIDTH. Build option: FFT_OUT_FRAMER_ROUND_EN.
module fft_out_framer #(
  parameter int unsigned IWIDTH = 21,
  parameter int unsigned OWIDTH = 16,
  parameter int unsigned LGSIZE = 11,
  parameter int unsigned LGFIFO = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_ce,
  input  logic [2*IWIDTH-1:0]   i_sample,
  input  logic                  i_sync,
  input  logic                  i_clear,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [2*OWIDTH-1:0]   o_data,
  output logic                  o_first,
  output logic                  o_last,
  output logic                  o_overflow
);

  localparam int unsigned D     = IWIDTH - OWIDTH;
  localparam int unsigned Depth = 2 ** LGFIFO;
  localparam int unsigned EW    = 2 * OWIDTH + 2;

`ifdef FFT_OUT_FRAMER_ROUND_EN
  localparam logic [IWIDTH:0] RndBias = (IWIDTH + 1)'((2 ** (D - 1)) - 1);
`endif

  typedef enum logic [1:0] {StIdle, StStream, StResync} state_e;

  function automatic logic [OWIDTH-1:0] round_comp(input logic [IWIDTH-1:0] x);
`ifdef FFT_OUT_FRAMER_ROUND_EN
    logic [IWIDTH:0] sum;
    logic [OWIDTH:0] q;
    sum = {x[IWIDTH-1], x} + RndBias + (IWIDTH + 1)'(x[D]);
    q   = sum[IWIDTH:D];
    // Only a positive carry can push past the top; negative sums never underflow.
    if (q[OWIDTH] != q[OWIDTH-1]) begin
      round_comp = {1'b0, {(OWIDTH - 1){1'b1}}};
    end else begin
      round_comp = q[OWIDTH-1:0];
    end
`else
    round_comp = x[IWIDTH-1:D];
`endif
  endfunction

  state_e               state_q, state_d;
  logic [LGSIZE-1:0]    frm_cnt_q, frm_cnt_d;
  logic [LGFIFO:0]      fifo_cnt_q, fifo_cnt_d;
  logic [LGFIFO-1:0]    wr_ptr_q, rd_ptr_q;
  logic                 ovf_q, ovf_d;
  logic [EW-1:0]        mem [Depth];

  logic                 full, rd_en, wr_req, wr_en, drop;
  logic [LGSIZE-1:0]    frm_pos;
  logic                 ent_first, ent_last;
  logic [2*OWIDTH-1:0]  rnd_data;
  logic [EW-1:0]        head;

  assign rnd_data = {round_comp(i_sample[2*IWIDTH-1:IWIDTH]), round_comp(i_sample[IWIDTH-1:0])};

  always_comb begin
    full      = (fifo_cnt_q == (LGFIFO + 1)'(Depth));
    rd_en     = o_valid && i_ready;
    // The sync sample itself is written when leaving IDLE/RESYNC.
    wr_req    = i_ce && ((state_q == StStream) || i_sync);
    drop      = wr_req && full && !rd_en;
    wr_en     = wr_req && !drop;
    frm_pos   = i_sync ? '0 : frm_cnt_q;
    ent_first = (frm_pos == '0);
    ent_last  = (frm_pos == '1);

    state_d = state_q;
    unique case (state_q)
      StIdle, StResync: if (i_ce && i_sync) state_d = StStream;
      StStream:         state_d = StStream;
      default:          state_d = StIdle;
    endcase
    if (drop) state_d = StResync;

    frm_cnt_d  = wr_en ? frm_pos + LGSIZE'(1) : frm_cnt_q;
    fifo_cnt_d = fifo_cnt_q + (LGFIFO + 1)'(wr_en) - (LGFIFO + 1)'(rd_en);
    ovf_d      = drop ? 1'b1 : (i_clear ? 1'b0 : ovf_q);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= StIdle;
      frm_cnt_q  <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      frm_cnt_q  <= frm_cnt_d;
      fifo_cnt_q <= fifo_cnt_d;
      ovf_q      <= ovf_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + LGFIFO'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + LGFIFO'(1);
    end
  end

  // Storage needs no reset; outputs are qualified by the reset count.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr_q] <= {ent_first, ent_last, rnd_data};
  end

  always_comb begin
    head       = mem[rd_ptr_q];
    o_valid    = (fifo_cnt_q != '0);
    o_first    = o_valid && head[EW-1];
    o_last     = o_valid && head[EW-2];
    o_data     = head[2*OWIDTH-1:0];
    o_overflow = ovf_q;
  end

endmodule

// File: tb/tb_fft_out_framer.sv
// Directed bench for fft_out_framer (default parameters); expectations follow
// FFT_OUT_FRAMER_ROUND_EN when it is defined.
module tb_fft_out_framer;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_ce;
  logic [41:0] i_sample;
  logic        i_sync;
  logic        i_clear;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_data;
  logic        o_first;
  logic        o_last;
  logic        o_overflow;

  int n_vec = 0;
  int n_err = 0;

  fft_out_framer dut (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_ce       (i_ce),
    .i_sample   (i_sample),
    .i_sync     (i_sync),
    .i_clear    (i_clear),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_first    (o_first),
    .o_last     (o_last),
    .o_overflow (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Sample n as real = n*32, imag = -n*32: exact under both rounding modes.
  function automatic logic [41:0] mk(input int n);
    logic [20:0] re, im;
    re = 21'(n * 32);
    im = 21'(-n * 32);
    return {re, im};
  endfunction

  function automatic logic [31:0] ex(input int n);
    return {16'(n), 16'(-n)};
  endfunction

  task automatic drive(input logic [41:0] smp, input logic sync);
    i_ce     = 1'b1;
    i_sync   = sync;
    i_sample = smp;
    @(posedge i_clk);
    #1;
    i_ce   = 1'b0;
    i_sync = 1'b0;
  endtask

  task automatic send_chk(input string tag, input int n, input logic sync,
                          input logic ef, input logic el);
    drive(mk(n), sync);
    check(tag, {29'd0, o_valid, o_first, o_last, o_data}, {29'd0, 1'b1, ef, el, ex(n)});
  endtask

  task automatic idle_step();
    @(posedge i_clk);
    #1;
  endtask

`ifdef FFT_OUT_FRAMER_ROUND_EN
  localparam bit Rnd = 1'b1;
`else
  localparam bit Rnd = 1'b0;
`endif

  logic [20:0] rv_re  [5] = '{21'd48, 21'd80, 21'd112, 21'h0FFFF0, 21'h100000};
  logic [20:0] rv_im  [5] = '{21'h1FFFD0, 21'h1FFFB0, 21'd0, 21'd0, 21'd0};
  logic [15:0] rx_re  [5] = '{16'd2, 16'd2, 16'd4, 16'h7FFF, 16'h8000};
  logic [15:0] rx_im  [5] = '{16'hFFFE, 16'hFFFE, 16'd0, 16'd0, 16'd0};
  logic [15:0] tx_re  [5] = '{16'd1, 16'd2, 16'd3, 16'h7FFF, 16'h8000};
  logic [15:0] tx_im  [5] = '{16'hFFFE, 16'hFFFD, 16'd0, 16'd0, 16'd0};

  initial begin
    i_reset_n = 1'b0;
    i_ce      = 1'b0;
    i_sample  = '0;
    i_sync    = 1'b0;
    i_clear   = 1'b0;
    i_ready   = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check("reset", {60'd0, o_valid, o_first, o_last, o_overflow}, 64'd0);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    idle_step();

    // No sync: everything discarded.
    i_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      drive(mk(k + 3), 1'b0);
      check("nosync_valid", {63'd0, o_valid}, 64'd0);
    end
    check("nosync_ovf", {63'd0, o_overflow}, 64'd0);

    // Two back-to-back frames at full throughput.
    for (int k = 0; k < 4096; k++) begin
      send_chk("frame", k, k == 0, (k % 2048) == 0, (k % 2048) == 2047);
    end
    idle_step();
    check("frame_drain", {63'd0, o_valid}, 64'd0);

    // Rounding vectors.
    for (int k = 0; k < 5; k++) begin
      drive({rv_re[k], rv_im[k]}, k == 0);
      check("round", {29'd0, o_valid, o_first, o_last, o_data},
            {29'd0, 1'b1, k == 0, 1'b0,
             Rnd ? {rx_re[k], rx_im[k]} : {tx_re[k], tx_im[k]}});
    end
    idle_step();

    // Fill with no reader, then overflow.
    i_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      drive(mk(k), k == 0);
      check("fill_hold", {30'd0, o_valid, o_first, o_data}, {30'd0, 1'b1, 1'b1, ex(0)});
    end
    check("fill_noovf", {63'd0, o_overflow}, 64'd0);
    drive(mk(16), 1'b0);
    check("ovf_set", {63'd0, o_overflow}, 64'd1);
    check("ovf_head", {29'd0, o_valid, o_first, o_last, o_data}, {29'd0, 3'b110, ex(0)});
    i_ready = 1'b1;
    for (int k = 1; k < 16; k++) begin
      drive(mk(16 + k), 1'b0);
      check("ovf_drain", {29'd0, o_valid, o_first, o_last, o_data}, {29'd0, 3'b100, ex(k)});
    end
    for (int k = 0; k < 3; k++) begin
      drive(mk(40 + k), 1'b0);
      check("resync_discard", {63'd0, o_valid}, 64'd0);
    end
    send_chk("resync_first", 0, 1'b1, 1'b1, 1'b0);
    check("ovf_sticky", {63'd0, o_overflow}, 64'd1);
    i_clear = 1'b1;
    send_chk("clear_data", 1, 1'b0, 1'b0, 1'b0);
    i_clear = 1'b0;
    check("ovf_clear", {63'd0, o_overflow}, 64'd0);

    // Premature sync at count 100, then a full-length frame.
    for (int k = 2; k < 100; k++) send_chk("short", k, 1'b0, 1'b0, 1'b0);
    send_chk("realign", 0, 1'b1, 1'b1, 1'b0);
    for (int k = 1; k < 2048; k++) send_chk("long", k, 1'b0, 1'b0, k == 2047);
    idle_step();

    // Full FIFO with concurrent read still accepts the write.
    i_ready = 1'b0;
    for (int k = 0; k < 16; k++) drive(mk(k), k == 0);
    i_ready = 1'b1;
    drive(mk(16), 1'b0);
    check("full_rw_ovf", {63'd0, o_overflow}, 64'd0);
    check("full_rw_head", {29'd0, o_valid, o_first, o_last, o_data}, {29'd0, 3'b100, ex(1)});
    i_ready = 1'b0;

    // Asynchronous reset mid-frame.
    #2;
    i_reset_n = 1'b0;
    #1;
    check("async_rst", {60'd0, o_valid, o_first, o_last, o_overflow}, 64'd0);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    i_ready   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(mk(5 + k), 1'b0);
      check("post_rst_idle", {63'd0, o_valid}, 64'd0);
    end
    send_chk("post_rst_sync", 0, 1'b1, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
